// File: rtl/fm_seek_ctrl.sv
// FM tuning controller: owns the NCO phase increment, performs direct tunes and
// up/down channel seeks that settle, average the vectran magnitude and stop on a station.
module fm_seek_ctrl #(
  parameter int unsigned             PHI_WIDTH  = 32,
  parameter int unsigned             MAG_WIDTH  = 16,
  parameter logic [PHI_WIDTH-1:0]    PHI_MIN    = 32'd132353593,
  parameter logic [PHI_WIDTH-1:0]    PHI_MAX    = 32'd1996488704,
  parameter logic [PHI_WIDTH-1:0]    PHI_STEP   = 32'd5825422,
  parameter int unsigned             MAX_STEPS  = 320,
  parameter int unsigned             SETTLE_SMP = 64,
  parameter int unsigned             AVG_LOG2   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [PHI_WIDTH-1:0] cmd_phi,
  input  logic [MAG_WIDTH-1:0] threshold,
  input  logic [MAG_WIDTH-1:0] mag,
  input  logic                 mag_valid,
  output logic [PHI_WIDTH-1:0] phi_inc,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [MAG_WIDTH-1:0] mag_avg
);

  localparam int unsigned AVG_N  = 1 << AVG_LOG2;
  localparam int unsigned ACC_W  = MAG_WIDTH + AVG_LOG2;
  localparam int unsigned SMP_W  = $clog2((SETTLE_SMP > AVG_N) ? SETTLE_SMP : AVG_N) + 1;
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

  localparam logic [PHI_WIDTH:0] MIN_X  = {1'b0, PHI_MIN};
  localparam logic [PHI_WIDTH:0] MAX_X  = {1'b0, PHI_MAX};
  localparam logic [PHI_WIDTH:0] STEP_X = {1'b0, PHI_STEP};

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_SETTLE, S_MEASURE, S_DECIDE
  } state_t;

  state_t                state_q, state_d;
  logic [PHI_WIDTH-1:0]  phi_q, phi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [MAG_WIDTH-1:0]  avg_q, avg_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [SMP_W-1:0]      smp_q, smp_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  seek_q, seek_d;
  logic                  dir_q, dir_d;

  logic [MAG_WIDTH-1:0]  avg_c;
  logic [PHI_WIDTH:0]    up_sum_c;
  logic                  abort_c;

  assign avg_c    = MAG_WIDTH'(acc_q >> AVG_LOG2);
  assign up_sum_c = {1'b0, phi_q} + STEP_X;
  assign abort_c  = cmd_valid && (cmd_op == 2'b11);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    phi_d   = phi_q;
    done_d  = 1'b0;
    found_d = found_q;
    avg_d   = avg_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    step_d  = step_q;
    seek_d  = seek_q;
    dir_d   = dir_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              phi_d   = cmd_phi;
              seek_d  = 1'b0;
              smp_d   = '0;
              acc_d   = '0;
              state_d = S_SETTLE;
            end
            2'b01, 2'b10: begin
              seek_d  = 1'b1;
              dir_d   = cmd_op[1];
              step_d  = '0;
              state_d = S_STEP;
            end
            default: ;
          endcase
        end
      end
      S_STEP: begin
        // Wide compares keep the band-edge wrap free of overflow
        if (!dir_q) begin
          phi_d = (up_sum_c > MAX_X) ? PHI_MIN : PHI_WIDTH'(up_sum_c);
        end else begin
          phi_d = ({1'b0, phi_q} < (MIN_X + STEP_X)) ? PHI_MAX : (phi_q - PHI_STEP);
        end
        step_d  = step_q + STEP_W'(1);
        smp_d   = '0;
        acc_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (mag_valid) begin
          if (smp_q == SMP_W'(SETTLE_SMP - 1)) begin
            smp_d   = '0;
            state_d = S_MEASURE;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
      S_MEASURE: begin
        if (mag_valid) begin
          acc_d = acc_q + ACC_W'(mag);
          if (smp_q == SMP_W'(AVG_N - 1)) begin
            smp_d   = '0;
            state_d = S_DECIDE;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
      S_DECIDE: begin
        avg_d = avg_c;
        acc_d = '0;
        if (!seek_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (avg_c >= threshold) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (step_q == STEP_W'(MAX_STEPS)) begin
          found_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the busy state was about to do
    if ((state_q != S_IDLE) && abort_c) begin
      state_d = S_IDLE;
      phi_d   = phi_q;
      avg_d   = avg_q;
      done_d  = 1'b1;
      found_d = 1'b0;
      smp_d   = '0;
      acc_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phi_q   <= PHI_MIN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      avg_q   <= '0;
      acc_q   <= '0;
      smp_q   <= '0;
      step_q  <= '0;
      seek_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phi_q   <= phi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      avg_q   <= avg_d;
      acc_q   <= acc_d;
      smp_q   <= smp_d;
      step_q  <= step_d;
      seek_q  <= seek_d;
      dir_q   <= dir_d;
    end
  end

  assign phi_inc = phi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign mag_avg = avg_q;

endmodule

// File: tb/tb_fm_seek_ctrl.sv
// Directed bench for fm_seek_ctrl: a table of tune/seek commands with hand-computed
// results, followed by hand-written abort and reset-in-flight sequences.
module tb_fm_seek_ctrl;

  localparam logic [31:0] PMIN  = 32'd132353593;
  localparam logic [31:0] PMAX  = 32'd1996488704;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_phi;
  logic [15:0] threshold;
  logic [15:0] mag;
  logic        mag_valid;
  logic [31:0] phi_inc;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] mag_avg;

  int total = 0;
  int bad   = 0;
  int cur   = -1;

  fm_seek_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_phi   (cmd_phi),
    .threshold (threshold),
    .mag       (mag),
    .mag_valid (mag_valid),
    .phi_inc   (phi_inc),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .mag_avg   (mag_avg)
  );

  always #5 clk = ~clk;

  // mode 0: mag = (phi_inc >= edge_phi) ? hi : lo
  // mode 1: first 64 strobes lo, later strobes hi
  // mode 2: alternate lo/hi per strobe
  typedef struct {
    logic [1:0]  op;
    logic [31:0] phi;
    logic [15:0] thr;
    int          mode;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] edge_phi;
    int          period;
    logic [31:0] exp_phi;
    logic        exp_found;
    logic [15:0] exp_avg;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] phi,
                              input logic [15:0] thr, input int mode,
                              input logic [15:0] lo, input logic [15:0] hi,
                              input logic [31:0] edge_phi, input int period,
                              input logic [31:0] exp_phi, input logic exp_found,
                              input logic [15:0] exp_avg);
    vec_t v;
    v.op = op; v.phi = phi; v.thr = thr; v.mode = mode; v.lo = lo; v.hi = hi;
    v.edge_phi = edge_phi; v.period = period; v.exp_phi = exp_phi;
    v.exp_found = exp_found; v.exp_avg = exp_avg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0d, want %0d", name, cur, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input vec_t v, input int idx);
    case (v.mode)
      0:       return (phi_inc >= v.edge_phi) ? v.hi : v.lo;
      1:       return (idx < 64) ? v.lo : v.hi;
      default: return (idx % 2 == 1) ? v.hi : v.lo;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    int  strobes = 0;
    int  cyc = 0;
    bit  seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_phi = v.phi; threshold = v.thr; mag_valid = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.op == 2'b00) chk("tune_phi_next_clk", phi_inc, v.phi);
    chk("busy_after_cmd", 32'(busy), 32'd1);
    while (!seen && cyc < 40000) begin
      if (cyc % v.period == 0) begin
        mag_valid = 1'b1;
        mag = pick(v, strobes);
        strobes++;
      end else begin
        mag_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    mag_valid = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("phi_inc", phi_inc, v.exp_phi);
    chk("found", 32'(found), 32'(v.exp_found));
    chk("mag_avg", 32'(mag_avg), 32'(v.exp_avg));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(2'b00, PMIN,           16'd0,   1, 16'd0,   16'd64,  32'd0, 1, PMIN,           1'b0, 16'd64);
    vecs[1]  = mk(2'b00, 32'd200000000,  16'd0,   0, 16'd0,   16'd1000,32'd0, 3, 32'd200000000,  1'b0, 16'd1000);
    vecs[2]  = mk(2'b00, PMIN,           16'd0,   2, 16'd3,   16'd4,   32'd0, 1, PMIN,           1'b0, 16'd3);
    vecs[3]  = mk(2'b01, 32'd0,          16'd500, 0, 16'd100, 16'd800, 32'd149829859, 1, 32'd149829859, 1'b1, 16'd800);
    vecs[4]  = mk(2'b00, 32'd199999999,  16'd0,   0, 16'd0,   16'd7,   32'd0, 1, 32'd199999999,  1'b1, 16'd7);
    vecs[5]  = mk(2'b10, 32'd0,          16'd800, 0, 16'd0,   16'd800, 32'd0, 1, 32'd194174577,  1'b1, 16'd800);
    vecs[6]  = mk(2'b00, 32'd1996488604, 16'd0,   0, 16'd0,   16'd0,   32'd0, 1, 32'd1996488604, 1'b1, 16'd0);
    vecs[7]  = mk(2'b01, 32'd0,          16'd0,   0, 16'd0,   16'd0,   32'd0, 1, PMIN,           1'b1, 16'd0);
    vecs[8]  = mk(2'b10, 32'd0,          16'd0,   0, 16'd0,   16'd9,   32'd0, 1, PMAX,           1'b1, 16'd9);
    vecs[9]  = mk(2'b00, 32'd1990663282, 16'd0,   0, 16'd0,   16'd2,   32'd0, 1, 32'd1990663282, 1'b1, 16'd2);
    vecs[10] = mk(2'b01, 32'd0,          16'd2,   0, 16'd0,   16'd2,   32'd0, 1, PMAX,           1'b1, 16'd2);
    vecs[11] = mk(2'b00, 32'd138179015,  16'd0,   0, 16'd0,   16'd1,   32'd0, 1, 32'd138179015,  1'b1, 16'd1);
    vecs[12] = mk(2'b10, 32'd0,          16'd1,   0, 16'd0,   16'd1,   32'd0, 1, PMIN,           1'b1, 16'd1);
    vecs[13] = mk(2'b10, 32'd0,          16'd1,   0, 16'd0,   16'd0,   32'd0, 1, 32'd138179086,  1'b0, 16'd0);
    vecs[14] = mk(2'b00, 32'd400000000,  16'd0,   0, 16'd0,   16'd20,  32'd0, 1, 32'd400000000,  1'b0, 16'd20);
    vecs[15] = mk(2'b01, 32'd0,          16'd20,  0, 16'd0,   16'd20,  32'd0, 1, 32'd405825422,  1'b1, 16'd20);

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_phi = '0;
    threshold = '0; mag = '0; mag_valid = 1'b0;

    // Reset values, then an idle stretch with stray strobes
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phi", phi_inc, PMIN);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_avg", 32'(mag_avg), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mag_valid = i[0]; mag = 16'd999;
      @(posedge clk); #1;
    end
    mag_valid = 1'b0;
    chk("idle_phi", phi_inc, PMIN);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_avg", 32'(mag_avg), 32'd0);

    for (int k = 0; k < 16; k++) begin
      cur = k;
      run_vec(vecs[k]);
    end

    // Abort mid-SETTLE with a seek command ignored while busy
    cur = 100;
    threshold = 16'd100;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0; mag_valid = 1'b1; mag = 16'd0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("seek_busy", 32'(busy), 32'd1);
    chk("seek_stepped_phi", phi_inc, 32'd411650844);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ignored_cmd_phi", phi_inc, 32'd411650844);
    chk("ignored_cmd_busy", 32'(busy), 32'd1);
    chk("ignored_cmd_done", 32'(done), 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_phi", phi_inc, 32'd411650844);
    chk("abort_avg", 32'(mag_avg), 32'd20);
    @(posedge clk); #1;
    chk("abort_done_pulse", 32'(done), 32'd0);

    // Abort while idle is a no-op
    cur = 101;
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("idle_abort_done2", 32'(done), 32'd0);

    // Reset in the middle of MEASURE
    cur = 102;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_phi = 32'd300000000;
    @(posedge clk); #1;
    cmd_valid = 1'b0; mag_valid = 1'b1; mag = 16'd50;
    repeat (70) begin
      @(posedge clk); #1;
    end
    chk("measure_busy", 32'(busy), 32'd1);
    chk("measure_phi", phi_inc, 32'd300000000);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; mag_valid = 1'b0;
    chk("midrst_phi", phi_inc, PMIN);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_found", 32'(found), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_avg", 32'(mag_avg), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
